// File: rtl/lab_seq_ctrl.sv
// lab_seq_ctrl: clocked operator-sequence controller feeding the hex display.
// Walks IDLE->READY->ARMED->LOADED->COMMIT->DONE, with arm/commit handled as
// rising edges and a DONE/ERROR->READY restart on a new arm edge.
// Optional inactivity timeout: define LAB_SEQ_TIMEOUT_EN to build the idle
// counter and make ERROR reachable; otherwise err is tied low.
module lab_seq_ctrl #(
  parameter int CODE_W  = 4,
  parameter int SEL_W   = 2,
  parameter int BASE    = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              load,
  input  logic [SEL_W-1:0]  sel,
  input  logic              commit,
  output logic [CODE_W-1:0] out,
  output logic [2:0]        state_o,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_ARMED  = 3'd2,
    ST_LOADED = 3'd3,
    ST_COMMIT = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Status codes, zero-extended to the display width
  localparam logic [CODE_W-1:0] CODE_0 = CODE_W'(4'h0);
  localparam logic [CODE_W-1:0] CODE_A = CODE_W'(4'hA);
  localparam logic [CODE_W-1:0] CODE_B = CODE_W'(4'hB);
  localparam logic [CODE_W-1:0] CODE_C = CODE_W'(4'hC);
  localparam logic [CODE_W-1:0] CODE_D = CODE_W'(4'hD);
  localparam logic [CODE_W-1:0] CODE_E = CODE_W'(4'hE);
  localparam logic [CODE_W-1:0] CODE_F = CODE_W'(4'hF);

  if (CODE_W < 4 || TIMEOUT < 1) begin : g_param_check
    $error("lab_seq_ctrl: CODE_W must be >= 4 and TIMEOUT must be >= 1");
  end

  // Select-to-code mapping; the sum wraps silently at the display width
  function automatic logic [CODE_W-1:0] sel_to_code(input logic [SEL_W-1:0] s);
    return CODE_W'(32'(BASE) + 32'(s));
  endfunction

  state_e            state_q, state_d;
  logic [CODE_W-1:0] out_q, out_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic              arm_q, commit_q;
  logic              done_q;
  logic              arm_rise_s, commit_rise_s, tmo_s;

  assign arm_rise_s    = arm & ~arm_q;
  assign commit_rise_s = commit & ~commit_q;

`ifdef LAB_SEQ_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              err_q;

  assign tmo_s = (tcnt_q == TCNT_W'(TIMEOUT - 1));

  // Idle counter: advances only while waiting in ARMED/LOADED with load low
  always_comb begin
    tcnt_d = {TCNT_W{1'b0}};
    if (((state_q == ST_ARMED) || (state_q == ST_LOADED)) &&
        (state_d == state_q) && !load) begin
      tcnt_d = tcnt_q + TCNT_W'(1'b1);
    end else begin
      tcnt_d = {TCNT_W{1'b0}};
    end
  end

  // Idle counter and error flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= {TCNT_W{1'b0}};
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= (state_d == ST_ERROR);
    end
  end

  assign err = err_q;
`else
  assign tmo_s = 1'b0;
  assign err   = 1'b0;
`endif

  // Next-state, next-code and data capture; load beats commit beats timeout
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_READY;
        out_d   = CODE_B;
      end
      ST_READY: begin
        if (arm_rise_s) begin
          state_d = ST_ARMED;
          out_d   = CODE_A;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARMED, ST_LOADED: begin
        if (load) begin
          state_d = ST_LOADED;
          data_d  = sel_to_code(sel);
          out_d   = sel_to_code(sel);
        end else if ((state_q == ST_LOADED) && commit_rise_s) begin
          state_d = ST_COMMIT;
          out_d   = data_q[0] ? CODE_0 : CODE_E;
        end else if (tmo_s) begin
          state_d = ST_ERROR;
          out_d   = CODE_D;
        end else begin
          state_d = state_q;
        end
      end
      ST_COMMIT: begin
        if (!arm) begin
          state_d = ST_DONE;
          out_d   = CODE_F;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (arm_rise_s) begin
          state_d = ST_READY;
          out_d   = CODE_B;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = CODE_C;
        data_d  = {CODE_W{1'b0}};
      end
    endcase
  end

  // State, display code, captured data and edge-detect history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      out_q    <= CODE_C;
      data_q   <= {CODE_W{1'b0}};
      arm_q    <= 1'b0;
      commit_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      data_q   <= data_d;
      arm_q    <= arm;
      commit_q <= commit;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign out     = out_q;
  assign state_o = state_q;
  assign done    = done_q;

endmodule
